dc_level_decoder: RTL and testbench

Receive-side counterpart to the DC sequencer. It watches an ADC input driven by a stepped DC source, detects each new plateau, and reports the averaged plateau level and a running step count. It sits in CustomInstrument between an input channel (inputa..d) and the status registers. Its thresholds and timing come from one control register.

---
 rtl/dc_decoder_pkg.sv | 31 +++
 rtl/dc_window_avg.sv | 60 ++++++
 rtl/dc_level_decoder.sv | 174 +++++++++++++++++
 tb/tb_dc_level_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_decoder_pkg.sv
// dc_decoder_pkg: shared types and constants for the DC level decoder.
//   - state_e   : decoder FSM states
//   - *Default  : default widths for the decoder and its window averager
//   - acc_width : accumulator width (sample width plus growth for N = 2**avg_log2 samples)
//   - sat_inc   : increment that holds at the all-ones value of a given width
package dc_decoder_pkg;

  localparam int unsigned DataWDefault   = 16;
  localparam int unsigned AvgLog2Default = 4;
  localparam int unsigned CntWDefault    = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StMeasure = 2'd2
  } state_e;

  // A sum of 2**avg_log2 signed data_w samples always fits in data_w + avg_log2 bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned avg_log2);
    return data_w + avg_log2;
  endfunction

  // Saturating increment on the low 'width' bits (width in 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = 32'hFFFF_FFFF >> (32 - width);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/dc_window_avg.sv
// dc_window_avg: accumulates a window of N = 2**AVG_LOG2 signed samples.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   start       : synchronous restart (accumulator and index cleared)
//   run         : accumulate one sample per cycle while high; cleared while low
//   sample      : signed input sample
//   done        : high on the cycle the Nth sample of the window is presented
//   avg         : floor((acc + sample) / N), valid while done is high
// The window restarts by itself after each done cycle.
module dc_window_avg
  import dc_decoder_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned AVG_LOG2 = AvgLog2Default
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic [DATA_W-1:0] sample,
  output logic              done,
  output logic [DATA_W-1:0] avg
);

  localparam int unsigned ACC_W = acc_width(DATA_W, AVG_LOG2);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext, sum, shifted;
  logic [AVG_LOG2-1:0]     idx_q, idx_d;

  assign sample_ext = {{AVG_LOG2{sample[DATA_W-1]}}, sample};
  assign sum        = acc_q + sample_ext;
  // Arithmetic shift floors toward minus infinity; the result always fits in DATA_W.
  assign shifted    = sum >>> AVG_LOG2;
  assign avg        = shifted[DATA_W-1:0];
  assign done       = run && (&idx_q);

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (start || !run || done) begin
      acc_d = '0;
      idx_d = '0;
    end else begin
      acc_d = sum;
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/dc_level_decoder.sv
// dc_level_decoder: detects plateaus of a stepped DC input and reports the averaged level.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   enable         : run the decoder; low returns to idle
//   clear          : synchronous clear of level/step_count (and min/max)
//   sample_in      : signed ADC sample, one per clock
//   threshold      : unsigned minimum |avg - level| that counts as a new step
//   settle_cycles  : dwell after each step or after enable before averaging
//   level          : last accepted plateau level (signed)
//   step_count     : number of accepted steps, saturating
//   level_valid    : one-cycle pulse when level/step_count update
//   busy           : high whenever the decoder is not idle
//   level_min/max  : extreme accepted levels; built only when DC_DECODER_MINMAX_EN
//                    is defined, otherwise tied to zero
module dc_level_decoder
  import dc_decoder_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned AVG_LOG2 = AvgLog2Default,
  parameter int unsigned CNT_W    = CntWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] threshold,
  input  logic [CNT_W-1:0]  settle_cycles,
  output logic [DATA_W-1:0] level,
  output logic [CNT_W-1:0]  step_count,
  output logic              level_valid,
  output logic              busy,
  output logic [DATA_W-1:0] level_min,
  output logic [DATA_W-1:0] level_max
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]    step_count_q, step_count_d;
  logic                level_valid_q, level_valid_d;
  logic                busy_q, busy_d;

  logic                win_done;
  logic [DATA_W-1:0]   win_avg;
  logic signed [DATA_W:0] delta;
  logic [DATA_W:0]     diff_mag;
  logic                first_step;
  logic                accept;
  logic                take;

  dc_window_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk    (clk),
    .reset  (reset),
    .start  (clear | ~enable),
    .run    (state_q == StMeasure),
    .sample (sample_in),
    .done   (win_done),
    .avg    (win_avg)
  );

  // One extra bit so the difference of two full-range signed values cannot wrap.
  assign delta      = $signed({win_avg[DATA_W-1], win_avg}) -
                      $signed({level_q[DATA_W-1], level_q});
  assign diff_mag   = delta[DATA_W] ? (~delta + 1'b1) : delta;
  assign first_step = (step_count_q == '0);
  assign accept     = first_step || (diff_mag > {1'b0, threshold});
  // Decision that actually lands: clear and enable-low both override it.
  assign take       = (state_q == StMeasure) && win_done && enable && !clear && accept;

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    level_d       = level_q;
    step_count_d  = step_count_q;
    level_valid_d = 1'b0;

    if (clear) begin
      level_d      = '0;
      step_count_d = '0;
      state_d      = enable ? StSettle : StIdle;
      settle_cnt_d = settle_cycles;
    end else if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d      = StSettle;
          settle_cnt_d = settle_cycles;
        end
        StSettle: begin
          if (settle_cnt_q == '0) begin
            state_d = StMeasure;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        StMeasure: begin
          // On reject the window restarts on its own and we stay here.
          if (take) begin
            level_d       = win_avg;
            step_count_d  = CNT_W'(sat_inc(32'(step_count_q), CNT_W));
            level_valid_d = 1'b1;
            state_d       = StSettle;
            settle_cnt_d  = settle_cycles;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      level_q       <= '0;
      step_count_q  <= '0;
      level_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      level_q       <= level_d;
      step_count_q  <= step_count_d;
      level_valid_q <= level_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign level       = level_q;
  assign step_count  = step_count_q;
  assign level_valid = level_valid_q;
  assign busy        = busy_q;

`ifdef DC_DECODER_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      min_d = '0;
      max_d = '0;
    end else if (take) begin
      // First accept since reset/clear seeds both extremes.
      if (first_step || ($signed(win_avg) < $signed(min_q))) min_d = win_avg;
      if (first_step || ($signed(win_avg) > $signed(max_q))) max_d = win_avg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign level_min = min_q;
  assign level_max = max_q;
`else
  assign level_min = '0;
  assign level_max = '0;
`endif

endmodule

// File: tb/tb_dc_level_decoder.sv
// Bench for dc_level_decoder: directed scenarios plus random plateaus, checked against a
// sample-list reference model with a pulse scoreboard.
module tb_dc_level_decoder;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int N  = 16;
`ifdef DC_DECODER_MINMAX_EN
  localparam bit MinMax = 1'b1;
`else
  localparam bit MinMax = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [DW-1:0] threshold = '0;
  logic [CW-1:0] settle_cycles = '0;
  logic [DW-1:0] level, level_min, level_max;
  logic [CW-1:0] step_count;
  logic          level_valid, busy;

  always #5 clk = ~clk;

  dc_level_decoder #(
    .DATA_W   (DW),
    .AVG_LOG2 (4),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .sample_in     (sample_in),
    .threshold     (threshold),
    .settle_cycles (settle_cycles),
    .level         (level),
    .step_count    (step_count),
    .level_valid   (level_valid),
    .busy          (busy),
    .level_min     (level_min),
    .level_max     (level_max)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a dwell countdown and a list of collected window samples.
  typedef struct {
    int cyc;
    int lvl;
    int cnt;
    int mn;
    int mx;
  } exp_t;

  exp_t sbq[$];
  bit   m_active = 1'b0;
  int   m_dwell  = 0;
  int   m_win[$];
  int   m_level = 0, m_count = 0, m_min = 0, m_max = 0;
  int   mcyc = 0;
  int   last_pulse = -1;
  int   nxt_thr = 0, nxt_settle = 0;

  function automatic int floor_div16(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_dwell  = 0;
    m_win.delete();
    m_level = 0; m_count = 0; m_min = 0; m_max = 0;
    sbq.delete();
  endtask

  task automatic model_step(input bit en, input bit clr, input int smp, input int thr,
                            input int settle);
    int   sum, avg, diff;
    exp_t e;
    if (clr) begin
      m_level = 0; m_count = 0; m_min = 0; m_max = 0;
      m_win.delete();
      m_active = en;
      m_dwell  = settle + 1;
    end else if (!en) begin
      m_active = 1'b0;
      m_win.delete();
    end else if (!m_active) begin
      m_active = 1'b1;
      m_dwell  = settle + 1;
      m_win.delete();
    end else if (m_dwell > 0) begin
      m_dwell--;
    end else begin
      m_win.push_back(smp);
      if (m_win.size() == N) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        avg  = floor_div16(sum);
        diff = avg - m_level;
        if (diff < 0) diff = -diff;
        if (m_count == 0 || diff > thr) begin
          if (m_count == 0) begin
            m_min = avg; m_max = avg;
          end else begin
            if (avg < m_min) m_min = avg;
            if (avg > m_max) m_max = avg;
          end
          m_level = avg;
          if (m_count < 65535) m_count++;
          m_dwell = settle + 1;
          e.cyc = mcyc + 1;
          e.lvl = m_level;
          e.cnt = m_count;
          e.mn  = MinMax ? m_min : 0;
          e.mx  = MinMax ? m_max : 0;
          sbq.push_back(e);
        end
        m_win.delete();
      end
    end
  endtask

  // Drive one cycle's inputs at the negedge and predict the next posedge.
  task automatic cycle(input bit en, input bit clr, input int smp);
    @(negedge clk);
    enable        = en;
    clear         = clr;
    sample_in     = DW'(smp);
    threshold     = DW'(nxt_thr);
    settle_cycles = CW'(nxt_settle);
    model_step(en, clr, smp, nxt_thr, nxt_settle);
  endtask

  // Monitor: state outputs every cycle, pulses against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      check("level", $signed(level), m_level);
      check("step_count", step_count, m_count);
      check("busy", busy, int'(m_active));
      check("level_min", $signed(level_min), MinMax ? m_min : 0);
      check("level_max", $signed(level_max), MinMax ? m_max : 0);
      if (level_valid) begin
        last_pulse = mcyc;
        total++;
        if (sbq.size() == 0 || sbq[0].cyc != mcyc) begin
          bad++;
          $display("FAIL pulse_spurious: got level_valid=1 at cycle %0d expected no pulse", mcyc);
        end else begin
          e = sbq.pop_front();
          check("pulse_level", $signed(level), e.lvl);
          check("pulse_count", step_count, e.cnt);
          check("pulse_min", $signed(level_min), e.mn);
          check("pulse_max", $signed(level_max), e.mx);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= mcyc) begin
        total++;
        bad++;
        $display("FAIL pulse_missed: got no pulse at cycle %0d expected level=%0d", mcyc,
                 sbq[0].lvl);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int en_cyc, val, len, guard;
    bit en, clr;

    // Reset state
    #1;
    check("rst_level", $signed(level), 0);
    check("rst_count", step_count, 0);
    check("rst_valid", level_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cycle(0, 0, 0);

    // Settle timing: 11 settle + 16 measure cycles
    nxt_thr = 100;
    nxt_settle = 10;
    cycle(1, 0, 1000);
    en_cyc = mcyc + 1;
    repeat (60) cycle(1, 0, 1000);
    check("settle_latency", last_pulse - en_cyc, 27);
    check("first_level", $signed(level), 1000);
    check("first_count", step_count, 1);

    // Threshold is strict
    repeat (60) cycle(1, 0, 1100);
    check("thr_equal_level", $signed(level), 1000);
    check("thr_equal_count", step_count, 1);
    repeat (60) cycle(1, 0, 1101);
    check("thr_above_level", $signed(level), 1101);
    check("thr_above_count", step_count, 2);

    // Floor rounding of a negative average
    cycle(1, 1, -3);
    for (int i = 0; i < 60; i++) cycle(1, 0, (i % 2) ? -2 : -3);
    check("round_level", $signed(level), -3);
    check("round_count", step_count, 1);

    // Abort mid-window
    guard = 0;
    while (!(m_active && m_dwell == 0 && m_win.size() == 8) && guard < 100) begin
      cycle(1, 0, 2000);
      guard++;
    end
    check("abort_reach", guard < 100, 1);
    repeat (4) cycle(0, 0, 2000);
    check("abort_level", $signed(level), -3);
    check("abort_count", step_count, 1);
    check("abort_busy", busy, 0);
    repeat (60) cycle(1, 0, 2000);
    check("reenable_level", $signed(level), 2000);

    // Clear coincident with a decision
    guard = 0;
    while (!(m_active && m_dwell == 0 && m_win.size() == 15) && guard < 100) begin
      cycle(1, 0, -500);
      guard++;
    end
    check("clr_reach", guard < 100, 1);
    cycle(1, 1, -500);
    @(posedge clk);
    #2;
    check("clr_valid", level_valid, 0);
    check("clr_level", $signed(level), 0);
    check("clr_count", step_count, 0);
    check("clr_busy", busy, 1);

    // Min/max tracking
    nxt_thr = 50;
    nxt_settle = 2;
    cycle(1, 1, 500);
    repeat (40) cycle(1, 0, 500);
    repeat (40) cycle(1, 0, -700);
    repeat (40) cycle(1, 0, 300);
    check("mm_min", $signed(level_min), MinMax ? -700 : 0);
    check("mm_max", $signed(level_max), MinMax ? 500 : 0);
    check("mm_level", $signed(level), 300);

    // Asynchronous reset mid-window
    guard = 0;
    while (!(m_active && m_dwell == 0 && m_win.size() == 5) && guard < 100) begin
      cycle(1, 0, 4000);
      guard++;
    end
    check("rstmid_reach", guard < 100, 1);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    model_reset();
    #1;
    check("rstmid_level", $signed(level), 0);
    check("rstmid_count", step_count, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_min", $signed(level_min), 0);
    check("rstmid_max", $signed(level_max), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) cycle(0, 0, 0);

    // Random plateaus with noise, enable drops, clears and control changes
    for (int p = 0; p < 60; p++) begin
      val = $urandom_range(0, 60000);
      val = val - 30000;
      len = $urandom_range(20, 80);
      if ($urandom_range(0, 3) == 0) nxt_thr = $urandom_range(0, 400);
      if ($urandom_range(0, 3) == 0) nxt_settle = $urandom_range(0, 15);
      for (int c = 0; c < len; c++) begin
        int noise;
        en  = ($urandom_range(0, 60) != 0);
        clr = ($urandom_range(0, 150) == 0);
        noise = $urandom_range(0, 4);
        cycle(en, clr, val + noise - 2);
      end
    end

    repeat (3) cycle(0, 0, 0);
    @(posedge clk);
    #2;
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
